// File: rtl/trace_addr_feeder.sv
// Small synchronous FIFO with a flush input; the head is read combinationally from the read pointer.
// Latency: a write is visible at the head on the next cycle. Backpressure: full/empty flags; callers never push when full.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[PW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

// Turns signed address deltas into absolute addresses for the sector cache and counts them per run.
// Latency: 1 cycle from delta accept to addr_valid_41 when the FIFO is empty; 1 address/cycle sustained.
// Backpressure: delta_ready_41 drops when the FIFO is full or LENGTH deltas were taken; adder_41 holds while not ready.
module trace_addr_feeder #(
  parameter int AW     = 31,
  parameter int DEPTH  = 4,
  parameter int LENGTH = 1500000
) (
  input  logic          clk_41,
  input  logic          rst_41,
  input  logic          start_41,
  input  logic [AW-1:0] delta_41,
  input  logic          delta_valid_41,
  output logic          delta_ready_41,
  output logic [AW-1:0] adder_41,
  output logic          addr_valid_41,
  input  logic          addr_ready_41,
  output logic [AW-1:0] issued_41,
  output logic          done_41
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LEN    = AW'(LENGTH);
  localparam logic [AW-1:0] LEN_M1 = AW'(LENGTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] sum;
  logic [AW-1:0] new_sum;
  logic [AW-1:0] accepted;
  logic [AW-1:0] head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_vld;
  logic          pop_rdy;
  logic          last_pop;

  assign push_vld = delta_valid_41 && delta_ready_41;
  assign pop_rdy  = addr_valid_41 && addr_ready_41;
  assign last_pop = pop_rdy && (issued_41 == LEN_M1);
  // Delta and sum share one width, so plain addition is the sign-extended, wrapping sum.
  assign new_sum  = sum + delta_41;

  always_ff @(posedge clk_41) begin
    if (rst_41) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_41) state_nxt = RUN;
      RUN:     if (start_41) state_nxt = RUN;
               else if (last_pop) state_nxt = DONE;
      DONE:    if (start_41) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    delta_ready_41 = 1'b0;
    addr_valid_41  = 1'b0;
    done_41        = 1'b0;
    adder_41       = '0;
    if (state == RUN) begin
      delta_ready_41 = !fifo_full && (accepted != LEN);
      addr_valid_41  = !fifo_empty;
      adder_41       = fifo_empty ? '0 : head_dat;
    end
    if (state == DONE) done_41 = 1'b1;
  end

  // A start pulse wins over any handshake in the same cycle: the run begins clean.
  always_ff @(posedge clk_41) begin
    if (rst_41 || start_41) begin
      sum       <= '0;
      accepted  <= '0;
      issued_41 <= '0;
    end else begin
      if (push_vld) begin
        sum      <= new_sum;
        accepted <= accepted + 1'b1;
      end
      if (pop_rdy) issued_41 <= issued_41 + 1'b1;
    end
  end

  fifo #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_41),
    .rst      (rst_41),
    .flush    (start_41),
    .push_vld (push_vld),
    .push_dat (new_sum),
    .pop_rdy  (pop_rdy),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule

// File: tb/tb_trace_addr_feeder.sv
// Scoreboard bench: the driver pushes prefix-sum expectations, a negedge monitor pops and compares on each handshake.
module tb_trace_addr_feeder;
  localparam int AW     = 31;
  localparam int DEPTH  = 4;
  localparam int LENGTH = 6;

  logic          clk_41 = 1'b0;
  logic          rst_41;
  logic          start_41;
  logic [AW-1:0] delta_41;
  logic          delta_valid_41;
  logic          delta_ready_41;
  logic [AW-1:0] adder_41;
  logic          addr_valid_41;
  logic          addr_ready_41;
  logic [AW-1:0] issued_41;
  logic          done_41;

  int            tests = 0;
  int            fails = 0;
  logic [AW-1:0] exp_q[$];
  int            pop_cnt = 0;
  logic [AW-1:0] m_sum;
  int            m_acc;
  bit            m_run;
  bit            chk_en = 1'b0;
  bit            rand_rdy = 1'b0;
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_adder;

  trace_addr_feeder #(.AW(AW), .DEPTH(DEPTH), .LENGTH(LENGTH)) dut (
    .clk_41         (clk_41),
    .rst_41         (rst_41),
    .start_41       (start_41),
    .delta_41       (delta_41),
    .delta_valid_41 (delta_valid_41),
    .delta_ready_41 (delta_ready_41),
    .adder_41       (adder_41),
    .addr_valid_41  (addr_valid_41),
    .addr_ready_41  (addr_ready_41),
    .issued_41      (issued_41),
    .done_41        (done_41)
  );

  always #5 clk_41 = ~clk_41;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_41);
    #1;
  endtask

  // Monitor: compares every issued address against the scoreboard and tracks per-run issue count.
  always @(negedge clk_41) begin
    if (chk_en) begin
      chk("issued", issued_41, pop_cnt);
      chk("done", done_41, (pop_cnt == LENGTH));
      if (prev_hold) begin
        chk("hold_valid", addr_valid_41, 1);
        chk("hold_addr", adder_41, prev_adder);
      end
      if (addr_valid_41 && addr_ready_41) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got %0h expected nothing at %0t", adder_41, $time);
        end else begin
          chk("addr", adder_41, exp_q.pop_front());
        end
        pop_cnt++;
      end
      prev_hold  = addr_valid_41 && !addr_ready_41;
      prev_adder = adder_41;
      if (rst_41 || start_41) begin
        exp_q.delete();
        pop_cnt   = 0;
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (rand_rdy) addr_ready_41 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_delta(input logic [AW-1:0] d, input int maxc, output bit ok);
    ok = 1'b0;
    delta_41 = d;
    delta_valid_41 = 1'b1;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge clk_41);
      if (delta_ready_41) begin
        chk("ready_legal", (m_run && m_acc < LENGTH), 1);
        ok = 1'b1;
        m_sum = m_sum + d;
        m_acc++;
        exp_q.push_back(m_sum);
      end
      tick();
    end
    delta_valid_41 = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] d);
    bit ok;
    drive_delta(d, 100, ok);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic start_run();
    start_41 = 1'b1;
    m_sum = '0;
    m_acc = 0;
    m_run = 1'b1;
    tick();
    start_41 = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    bit empty_seen = 1'b0;
    for (int n = 0; n < maxc && !empty_seen; n++) begin
      @(negedge clk_41);
      #2;
      if (exp_q.size() == 0) empty_seen = 1'b1;
    end
    if (!empty_seen) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      @(negedge clk_41);
      if (done_41) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got done_41=0 expected 1");
    end
    tick();
  endtask

  initial begin
    logic [AW-1:0] stall_d [6];
    logic [AW-1:0] rd;
    int            sd;
    int            idx;
    int            cnt;
    bit            ok;

    rst_41 = 1'b1; start_41 = 1'b0; delta_valid_41 = 1'b0; delta_41 = '0;
    addr_ready_41 = 1'b0; m_sum = '0; m_acc = 0; m_run = 1'b0;
    repeat (2) @(posedge clk_41);
    @(negedge clk_41);
    chk("rst_valid", addr_valid_41, 0);
    chk("rst_dready", delta_ready_41, 0);
    chk("rst_done", done_41, 0);
    chk("rst_issued", issued_41, 0);
    chk("rst_addr", adder_41, 0);
    tick();
    rst_41 = 1'b0;
    chk_en = 1'b1;

    // Basic prefix sums with the cache always ready.
    addr_ready_41 = 1'b1;
    start_run();
    send(AW'(100)); send(AW'(4)); send(AW'(4)); send(AW'(-8));
    wait_drain(20);
    chk("t1_issued", issued_41, 4);

    // Wrap past the top of the address space.
    start_run();
    send(31'h7FFF_FFFF); send(AW'(1));
    wait_drain(20);

    // Cache stalled: only DEPTH deltas fit, then order is preserved on release.
    stall_d = '{AW'(10), AW'(20), AW'(30), AW'(40), AW'(50), AW'(60)};
    start_run();
    addr_ready_41 = 1'b0;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      drive_delta(stall_d[idx], 1, ok);
      if (ok) idx++;
    end
    chk("t3_accepted", idx, DEPTH);
    @(negedge clk_41);
    chk("t3_dready", delta_ready_41, 0);
    tick();
    addr_ready_41 = 1'b1;
    while (idx < LENGTH) begin
      send(stall_d[idx]);
      idx++;
    end
    wait_done(50);

    // Offer more than LENGTH deltas: the surplus must be refused.
    start_run();
    cnt = 0;
    for (int i = 0; i < LENGTH + 2; i++) begin
      drive_delta(AW'(i * 3 + 1), 10, ok);
      if (ok) cnt++;
    end
    chk("t2_accepted", cnt, LENGTH);
    wait_done(50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_41);
      chk("t2_dready", delta_ready_41, 0);
      chk("t2_valid", addr_valid_41, 0);
    end
    tick();

    // Reset in the middle of a run with three addresses queued.
    start_run();
    addr_ready_41 = 1'b0;
    send(AW'(7)); send(AW'(8)); send(AW'(9));
    rst_41 = 1'b1;
    m_run = 1'b0; m_sum = '0; m_acc = 0;
    tick();
    rst_41 = 1'b0;
    @(negedge clk_41);
    chk("t5_valid", addr_valid_41, 0);
    chk("t5_issued", issued_41, 0);
    chk("t5_dready", delta_ready_41, 0);
    tick();
    addr_ready_41 = 1'b1;
    start_run();
    send(AW'(50));
    wait_drain(20);

    // Random deltas with random gaps on both sides, many short runs.
    rand_rdy = 1'b1;
    for (int r = 0; r < 170; r++) begin
      start_run();
      for (int i = 0; i < LENGTH; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 3) == 0) begin
          rd = AW'($urandom);
        end else begin
          sd = int'($urandom_range(0, 128)) - 64;
          rd = sd[AW-1:0];
        end
        send(rd);
      end
      wait_done(200);
    end
    rand_rdy = 1'b0;
    addr_ready_41 = 1'b1;
    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
